// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer and its shift register.
// State encoding, datapath sizing and the per-step direction encoding.
package shift_sequencer_pkg;

  localparam int WIDTH    = 43;
  localparam int STEP_MAX = 16;
  localparam int CNT_W    = $clog2(STEP_MAX + 1);

  localparam logic RIGHT3 = 1'b1;
  localparam logic LEFT1  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Step counts beyond the pattern length would index past the pattern.
  function automatic logic [CNT_W-1:0] clamp_steps(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(STEP_MAX)) ? CNT_W'(STEP_MAX) : n;
  endfunction

endpackage

// File: rtl/shift_register.sv
// 43-bit shift register: loads start_value when disabled, else shifts right by 3 or left by 1.
// One-cycle update; no backpressure, bits shifted out are lost and zeros are shifted in.
module shift_register #(
  parameter int WIDTH = shift_sequencer_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             shift_switch,
  input  logic [WIDTH-1:0] start_value,
  output logic [WIDTH-1:0] out_value
);
  import shift_sequencer_pkg::*;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = start_value;
    if (enable) begin
      if (shift_switch == RIGHT3) begin
        value_d = value_q >> 3;
      end else begin
        value_d = value_q << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign out_value = value_q;

endmodule

// File: rtl/shift_sequencer.sv
// Moore FSM sequencing one shift program per start: LOAD, N SHIFT cycles, DONE; done N+3 cycles after start.
// start is only sampled in IDLE; requests while busy are dropped, never queued.
module shift_sequencer #(
  parameter int WIDTH    = shift_sequencer_pkg::WIDTH,
  parameter int STEP_MAX = shift_sequencer_pkg::STEP_MAX,
  parameter int CNT_W    = shift_sequencer_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    start_value,
  input  logic [STEP_MAX-1:0] pattern,
  input  logic [CNT_W-1:0]    num_steps,
  input  logic                abort_en,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                zero_flag,
  output logic [CNT_W-1:0]    steps_done,
  output logic                sh_enable,
  output logic                sh_switch,
  output logic [WIDTH-1:0]    sh_start_value,
  input  logic [WIDTH-1:0]    sh_out_value
);
  import shift_sequencer_pkg::*;

  localparam int IDX_W = $clog2(STEP_MAX);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    step_q, step_d;
  logic [WIDTH-1:0]    start_value_q;
  logic [STEP_MAX-1:0] pattern_q;
  logic [CNT_W-1:0]    nsteps_q;
  logic                abort_q;
  logic [WIDTH-1:0]    result_q;
  logic                zero_q;
  logic [CNT_W-1:0]    steps_done_q;
  logic                done_q;
  logic                accept;
  logic                last_step;
  logic                abort_hit;

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_step = (step_q == (nsteps_q - CNT_W'(1)));
  assign abort_hit = abort_q && (sh_out_value == '0);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    sh_enable = 1'b0;
    sh_switch = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          step_d  = '0;
        end
      end
      ST_LOAD: begin
        state_d = (nsteps_q == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        sh_enable = 1'b1;
        sh_switch = pattern_q[step_q[IDX_W-1:0]];
        step_d    = step_q + CNT_W'(1);
        // The exit edge still shifts; on abort the value is already zero.
        if (last_step || abort_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_value_q <= '0;
      pattern_q     <= '0;
      nsteps_q      <= '0;
      abort_q       <= 1'b0;
    end else if (accept) begin
      start_value_q <= start_value;
      pattern_q     <= pattern;
      nsteps_q      <= clamp_steps(num_steps);
      abort_q       <= abort_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q     <= '0;
      zero_q       <= 1'b0;
      steps_done_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        result_q     <= sh_out_value;
        zero_q       <= (sh_out_value == '0);
        steps_done_q <= step_q;
      end
    end
  end

  assign sh_start_value = start_value_q;
  assign result         = result_q;
  assign zero_flag      = zero_q;
  assign steps_done     = steps_done_q;
  assign done           = done_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Controller for the 43-bit shift register datapath. It accepts one shift program per handshake: a start value, up to 16 per-step direction bits, and a step count. It then drives the shift register's `enable` and `shift_switch` controls cycle by cycle, and returns the final value with a one-cycle `done` pulse. It sits between the top-level control logic and the shift register instance, and is the only driver of that register's control inputs.

## Interface
Parameters:
- `WIDTH`, 43: datapath width; must match the shift register.
- `STEP_MAX`, 16: maximum steps per program.
- `CNT_W`, 5: step counter width; equals `$clog2(STEP_MAX+1)`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  program request; sampled only in IDLE.
- `start_value`  in  WIDTH  initial register value.
- `pattern`  in  STEP_MAX  per-step direction, LSB = step 0; 1 = right by 3, 0 = left by 1.
- `num_steps`  in  CNT_W  step count; 0..STEP_MAX; values above STEP_MAX are clamped to STEP_MAX.
- `abort_en`  in  1  when set, the program ends early once the register reads zero.
- `busy`  out  1  high in LOAD, SHIFT and DONE.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  WIDTH  final register value; held until the next `done`.
- `zero_flag`  out  1  result == 0; updated together with `result`.
- `steps_done`  out  CNT_W  number of shift edges issued; updated with `result`.
- `sh_enable`  out  1  to shift register `enable` (0 = load, 1 = shift).
- `sh_switch`  out  1  to shift register `shift_switch`.
- `sh_start_value`  out  WIDTH  to shift register `start_value`.
- `sh_out_value`  in  WIDTH  from shift register `out_value`.

## Operation
The controller is a four-state Moore FSM: IDLE, LOAD, SHIFT, DONE.

- **IDLE:**
  - `sh_enable` = 0, so the register continuously reloads `sh_start_value`.
  - When `start` = 1: latch `start_value` into `sh_start_value`, and latch `pattern`, clamped `num_steps` and `abort_en`. Clear the step counter. Go to LOAD.
- **LOAD:**
  - `sh_enable` = 0; the register loads the latched value on this edge.
  - If latched N = 0, go to DONE; otherwise go to SHIFT.
- **SHIFT:**
  - `sh_enable` = 1 and `sh_switch` = `pattern[step]`; the step counter increments every cycle.
  - Go to DONE when step == N-1, or when latched `abort_en` = 1 and `sh_out_value` == 0.
  - The edge on which the FSM exits still shifts. A zero value stays zero, so this is harmless.
- **DONE:**
  - `sh_enable` = 0 and `sh_switch` = 0.
  - On the exit edge, register `result` <= `sh_out_value`, `zero_flag`, `steps_done` <= counter, and `done` <= 1. Go to IDLE.
- `sh_switch` = 0 in every state except SHIFT.
- `start` while `busy` is ignored; it is neither queued nor counted.
- The controller never modifies values itself. Shift width rules (bits shifted out are lost, zeros shifted in) belong to the register.
- **Reset:**
  - Asynchronous; the FSM goes to IDLE immediately, including mid-program.
  - Outputs go to `busy` = 0, `done` = 0, `result` = 0, `zero_flag` = 0, `steps_done` = 0, `sh_enable` = 0, `sh_switch` = 0, `sh_start_value` = 0.
  - An in-flight program is discarded with no `done`.

## Timing
- Let E0 be the edge that samples `start`. LOAD occupies cycle E0→E1, and the register holds `start_value` after E1.
- SHIFT occupies N cycles. DONE is a single cycle.
- `done` is high in the cycle after edge E(N+2); for N = 0 that is the cycle after E2.
- The earliest next `start` is sampled on the edge at which `done` is high. Back-to-back programs are therefore separated by N+3 cycles.
- With abort, DONE follows the first SHIFT cycle in which `sh_out_value` == 0.
- `busy` rises after E0 and falls on the same edge that raises `done`.

## Structure
- Shared package contents:
  - State enum (IDLE/LOAD/SHIFT/DONE).
  - `WIDTH` = 43.
  - `STEP_MAX` = 16.
  - Direction encoding constants: RIGHT3 = 1, LEFT1 = 0.
- No sub-module. The shift register is instantiated beside this block by the parent, not inside it.
- The test bench connects this block to a real shift register instance.

## Test plan
- Left run: `start_value` = 1, `pattern` = 0, N = 5 -> `result` = 0x20, `steps_done` = 5, `zero_flag` = 0, `done` high after E7.
- Right run: `start_value` = 0x1000, `pattern` = 16'hFFFF, N = 2 -> `result` = 0x40.
- Mixed run: `start_value` = 0x100, `pattern` = 16'h0002, N = 3 -> `result` = 0x80.
- Edge cases:
  - `start_value` = 0x400_0000_0000, N = 1, left -> `result` = 0, `zero_flag` = 1.
  - N = 0 -> `result` = `start_value`, `done` after E2.
  - N = 31 -> clamped; `steps_done` = 16.
- Abort: `start_value` = 1, `pattern` = 16'h0001, N = 10, `abort_en` = 1 -> `result` = 0, `steps_done` = 2, `done` after E4. With `abort_en` = 0 -> `steps_done` = 10.
- Reset and busy `start`:
  - `rst_n` low during SHIFT step 3 -> `busy`, `sh_enable` and `done` go to 0 immediately, and no `done` pulse follows.
  - The next program completes normally.
  - `start` pulses while `busy` leave `result` unchanged.
